// File: rtl/alarm_state_controller.sv
// Arm/entry/alarm/disarm sequencer for the Disarm-Alarm board. Drives the RGB
// colour code plus countdown, alarm and remaining-tries status.
module alarm_state_controller #(
   parameter int unsigned TICK_CYCLES = 50_000_000,
   parameter int unsigned EXIT_S      = 10,
   parameter int unsigned ENTRY_S     = 15,
   parameter int unsigned GREEN_S     = 3,
   parameter logic [15:0] CODE        = 16'h1234,
   parameter int unsigned MAX_TRIES   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_arm,
   input  logic       sensor,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   input  logic       key_clear,
   output logic [2:0] input_color,
   output logic       alarm_active,
   output logic [7:0] sec_left,
   output logic [3:0] tries_left
);

   // State encoding doubles as the colour code sent to the RGB controller.
   typedef enum logic [2:0] {
      S_IDLE     = 3'b001,
      S_EXIT     = 3'b010,
      S_ARMED    = 3'b011,
      S_ALARM    = 3'b100,
      S_ENTRY    = 3'b101,
      S_DISARMED = 3'b110
   } state_t;

   localparam int unsigned   PW       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);

   state_t         state_q, state_d;
   logic [PW-1:0]  pre_q, pre_d;
   logic [7:0]     sec_q, sec_d;
   logic [3:0]     tries_q, tries_d;
   logic [1:0]     cnt_q, cnt_d;
   logic [11:0]    buf_q, buf_d;
   logic           alarm_q, alarm_d;

   logic tick, timed, expiry, code_active, digit_ok, code_done, code_ok, code_bad, trans;

   assign tick        = (pre_q == PRE_LAST);
   assign timed       = (state_q == S_EXIT) || (state_q == S_ENTRY) || (state_q == S_DISARMED);
   assign expiry      = timed && tick && (sec_q == 8'd1);
   assign code_active = (state_q == S_EXIT) || (state_q == S_ARMED) ||
                        (state_q == S_ENTRY) || (state_q == S_ALARM);
   assign digit_ok    = code_active && key_valid && !key_clear && (key_digit <= 4'd9);
   assign code_done   = digit_ok && (cnt_q == 2'd3);
   assign code_ok     = code_done && ({buf_q, key_digit} == CODE);
   assign code_bad    = code_done && !code_ok;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      if (code_ok) begin
         state_d = S_DISARMED;
      end else if (code_bad && (tries_q == 4'd1) && (state_q != S_ALARM)) begin
         state_d = S_ALARM;
      end else begin
         case (state_q)
            S_IDLE:     if (btn_arm) state_d = S_EXIT;
            S_EXIT:     if (expiry)  state_d = S_ARMED;
            S_ARMED:    if (sensor)  state_d = S_ENTRY;
            S_ENTRY:    if (expiry)  state_d = S_ALARM;
            S_DISARMED: if (expiry)  state_d = S_IDLE;
            S_ALARM:    state_d = S_ALARM;
            default:    state_d = S_IDLE;
         endcase
      end
   end

   assign trans = (state_d != state_q);

   always_comb begin
      pre_d   = (trans || tick) ? '0 : pre_q + 1'b1;
      sec_d   = sec_q;
      tries_d = tries_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      alarm_d = (state_d == S_ALARM);

      if (trans) begin
         case (state_d)
            S_EXIT:     sec_d = 8'(EXIT_S);
            S_ENTRY:    sec_d = 8'(ENTRY_S);
            S_DISARMED: sec_d = 8'(GREEN_S);
            default:    sec_d = 8'd0;
         endcase
      end else if (timed && tick) begin
         sec_d = sec_q - 8'd1;
      end

      if (trans && ((state_d == S_IDLE) || (state_d == S_DISARMED))) begin
         tries_d = 4'(MAX_TRIES);
      end else if (code_bad && (tries_q != 4'd0)) begin
         tries_d = tries_q - 4'd1;
      end

      // Clear beats a simultaneous digit; outside code-entry states the count stays 0.
      if (!code_active || key_clear) begin
         cnt_d = 2'd0;
      end else if (digit_ok) begin
         cnt_d = code_done ? 2'd0 : cnt_q + 2'd1;
         buf_d = {buf_q[7:0], key_digit};
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pre_q   <= '0;
         sec_q   <= 8'd0;
         tries_q <= 4'(MAX_TRIES);
         cnt_q   <= 2'd0;
         buf_q   <= 12'd0;
         alarm_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         sec_q   <= sec_d;
         tries_q <= tries_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         alarm_q <= alarm_d;
      end
   end

   assign input_color  = state_q;
   assign alarm_active = alarm_q;
   assign sec_left     = sec_q;
   assign tries_left   = tries_q;

endmodule

// File: tb/tb_alarm_state_controller.sv
// Directed bench for alarm_state_controller with short simulation timings.
module tb_alarm_state_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_arm, sensor, key_valid, key_clear;
   logic [3:0] key_digit;
   logic [2:0] input_color;
   logic       alarm_active;
   logic [7:0] sec_left;
   logic [3:0] tries_left;

   int errors = 0;
   int checks = 0;

   alarm_state_controller #(
      .TICK_CYCLES(10), .EXIT_S(3), .ENTRY_S(2), .GREEN_S(2),
      .CODE(16'h1234), .MAX_TRIES(3)
   ) dut (
      .clk(clk), .rst(rst), .btn_arm(btn_arm), .sensor(sensor),
      .key_valid(key_valid), .key_digit(key_digit), .key_clear(key_clear),
      .input_color(input_color), .alarm_active(alarm_active),
      .sec_left(sec_left), .tries_left(tries_left)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] d);
      key_digit = d;
      key_valid = 1'b1;
      step(1);
      key_valid = 1'b0;
   endtask

   task automatic code4(input logic [15:0] c);
      press(c[15:12]);
      press(c[11:8]);
      press(c[7:4]);
      press(c[3:0]);
   endtask

   task automatic arm;
      btn_arm = 1'b1;
      step(1);
      btn_arm = 1'b0;
   endtask

   task automatic trip;
      sensor = 1'b1;
      step(1);
      sensor = 1'b0;
   endtask

   initial begin
      rst = 1'b1; btn_arm = 1'b0; sensor = 1'b0;
      key_valid = 1'b0; key_clear = 1'b0; key_digit = 4'd0;
      step(2);
      check("rst_color", input_color, 3'b001);
      check("rst_alarm", alarm_active, 1'b0);
      check("rst_sec", sec_left, 8'd0);
      check("rst_tries", tries_left, 4'd3);
      rst = 1'b0;
      step(1);

      // Keys in IDLE must not advance the digit count.
      press(4'd1); press(4'd2); press(4'd3);
      check("idle_keys_color", input_color, 3'b001);
      check("idle_keys_tries", tries_left, 4'd3);

      arm();
      check("exit_color", input_color, 3'b010);
      check("exit_sec3", sec_left, 8'd3);
      step(9);
      check("exit_sec3_hold", sec_left, 8'd3);
      step(1);
      check("exit_sec2", sec_left, 8'd2);
      step(10);
      check("exit_sec1", sec_left, 8'd1);
      check("exit_color_hold", input_color, 3'b010);
      step(10);
      check("armed_color", input_color, 3'b011);
      check("armed_sec", sec_left, 8'd0);

      press(4'd4);
      check("idle_digits_dropped", input_color, 3'b011);
      check("idle_digits_tries", tries_left, 4'd3);
      key_clear = 1'b1; step(1); key_clear = 1'b0;

      // Trip, let entry expire into ALARM, then disarm.
      trip();
      check("entry_color", input_color, 3'b101);
      check("entry_sec", sec_left, 8'd2);
      step(19);
      check("entry_late_color", input_color, 3'b101);
      check("entry_late_sec", sec_left, 8'd1);
      step(1);
      check("alarm_color", input_color, 3'b100);
      check("alarm_active", alarm_active, 1'b1);
      check("alarm_sec", sec_left, 8'd0);
      press(4'd1); press(4'd2); press(4'd3);
      check("alarm_partial", input_color, 3'b100);
      press(4'd4);
      check("disarm_color", input_color, 3'b110);
      check("disarm_alarm", alarm_active, 1'b0);
      check("disarm_sec", sec_left, 8'd2);
      step(19);
      check("green_hold", input_color, 3'b110);
      step(1);
      check("green_to_idle", input_color, 3'b001);

      // Disarm race: 4th digit lands on the entry expiry edge.
      arm();
      step(30);
      check("race_armed", input_color, 3'b011);
      trip();
      step(16);
      press(4'd1); press(4'd2); press(4'd3);
      check("race_pre_color", input_color, 3'b101);
      check("race_pre_sec", sec_left, 8'd1);
      press(4'd4);
      check("race_color", input_color, 3'b110);
      check("race_alarm", alarm_active, 1'b0);
      step(20);
      check("race_idle", input_color, 3'b001);

      // Wrong codes in ARMED, third one forces ALARM.
      arm();
      step(30);
      check("wrong_armed", input_color, 3'b011);
      code4(16'h9999);
      check("wrong1_tries", tries_left, 4'd2);
      check("wrong1_color", input_color, 3'b011);
      code4(16'h9999);
      check("wrong2_tries", tries_left, 4'd1);
      check("wrong2_color", input_color, 3'b011);
      code4(16'h9999);
      check("forced_color", input_color, 3'b100);
      check("forced_alarm", alarm_active, 1'b1);
      check("forced_tries", tries_left, 4'd0);
      code4(16'h1234);
      check("forced_disarm", input_color, 3'b110);
      check("forced_reload", tries_left, 4'd3);
      step(20);
      check("wrong_idle", input_color, 3'b001);

      // Entry hygiene: clear+digit together drops the digit; digit 12 ignored.
      arm();
      step(30);
      press(4'd1); press(4'd2);
      key_clear = 1'b1; key_digit = 4'd3; key_valid = 1'b1;
      step(1);
      key_clear = 1'b0; key_valid = 1'b0;
      press(4'd4); press(4'd1); press(4'd2);
      check("hyg_partial_tries", tries_left, 4'd3);
      check("hyg_partial_color", input_color, 3'b011);
      press(4'd3);
      check("hyg_wrong_tries", tries_left, 4'd2);
      check("hyg_wrong_color", input_color, 3'b011);
      press(4'd1); press(4'd2); press(4'd3); press(4'd12); press(4'd4);
      check("hyg_disarm", input_color, 3'b110);
      check("hyg_reload", tries_left, 4'd3);
      step(20);

      // Async reset mid-cycle while in ALARM with a partial code pending.
      arm();
      step(30);
      trip();
      step(20);
      check("ar_alarm", input_color, 3'b100);
      press(4'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("ar_color", input_color, 3'b001);
      check("ar_alarm_off", alarm_active, 1'b0);
      check("ar_sec", sec_left, 8'd0);
      check("ar_tries", tries_left, 4'd3);
      step(1);
      rst = 1'b0;
      arm();
      press(4'd2); press(4'd3); press(4'd4);
      check("ar_partial_gone", input_color, 3'b010);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alarm_state_controller.md
Name: alarm_state_controller

Overview:
Top-level alarm sequencer for the Disarm-Alarm board. It takes the arm button, intrusion sensor and keypad digits, and runs the arm/entry/alarm/disarm state machine with second-resolution countdowns. It drives the 3-bit input_color code consumed directly by the downstream RGB LED controller, plus countdown and alarm status outputs for the display and buzzer stages.

Parameters:
TICK_CYCLES, 50_000_000, clk cycles per one-second tick (set to 10 in simulation)
EXIT_S, 10, exit delay in seconds after arming (1..255)
ENTRY_S, 15, entry delay in seconds after sensor trip (1..255)
GREEN_S, 3, seconds the disarmed/green indication is held (1..255)
CODE, 16'h1234, disarm code, 4 BCD digits, MS digit first
MAX_TRIES, 3, wrong codes tolerated before forced alarm (1..15)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-high reset
btn_arm  in  1  single-cycle arm pulse, already synchronised/debounced
sensor  in  1  intrusion sensor level, already synchronised; 1 = tripped
key_valid  in  1  single-cycle strobe, key_digit valid
key_digit  in  4  keypad digit 0..9; values 10..15 ignored
key_clear  in  1  single-cycle pulse, discards partial code entry
input_color  out  3  colour/mode code to the RGB controller
alarm_active  out  1  high only in ALARM
sec_left  out  8  remaining seconds in timed states, else 0
tries_left  out  4  remaining wrong-code allowance

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk. Reset forces state IDLE, input_color=3'b001, alarm_active=0, sec_left=0, tries_left=MAX_TRIES, digit count=0, prescaler=0.
- All outputs are registered and updated on the same edge as the state register. input_color always matches the current state.
- State / input_color encoding:
  - IDLE = 001 (white)
  - EXIT = 010 (yellow)
  - ARMED = 011 (cyan)
  - ALARM = 100 (red blink)
  - ENTRY = 101 (yellow)
  - DISARMED = 110 (green)
  - Code 000 is never driven.
- Transitions:
  - IDLE: btn_arm -> EXIT.
  - EXIT: timer expiry -> ARMED.
  - ARMED: sensor=1 -> ENTRY.
  - ENTRY: timer expiry -> ALARM.
  - DISARMED: timer expiry -> IDLE.
  - EXIT, ARMED, ENTRY, ALARM: correct code -> DISARMED.
  - EXIT, ARMED, ENTRY: wrong code with tries_left==1 -> ALARM.
  - btn_arm is ignored outside IDLE. sensor is ignored outside ARMED.
- Timer:
  - The prescaler counts 0..TICK_CYCLES-1 and emits a one-cycle tick at TICK_CYCLES-1.
  - The prescaler is cleared on every state transition, so the first second after entry is a full second.
  - On entry to EXIT, ENTRY or DISARMED, sec_left loads EXIT_S, ENTRY_S or GREEN_S respectively.
  - Each tick decrements sec_left.
  - A tick while sec_left==1 is expiry: the transition is taken that edge and sec_left becomes 0 (or the next state's load value).
- Code entry:
  - Active only in EXIT, ARMED, ENTRY and ALARM. In IDLE and DISARMED, keys are ignored and the digit count is held at 0.
  - A valid digit (0..9) with key_valid shifts into a 12-bit buffer and increments the count.
  - On the 4th digit, {buffer, key_digit} is compared to CODE combinationally; the verdict acts on that same edge, and the count returns to 0.
  - A wrong code decrements tries_left, saturating at 0.
  - In ALARM, a wrong code only clears the entry; the alarm persists.
  - key_clear zeroes the count. If key_clear and key_valid occur together, clear wins and the digit is dropped.
- tries_left reloads to MAX_TRIES on entry to IDLE and to DISARMED.
- Simultaneous events, priority order:
  - correct code > wrong-code forced alarm > timer expiry / sensor > btn_arm.
  - Example: correct code arriving on the ENTRY expiry edge -> DISARMED, not ALARM.
- Reset mid-operation (e.g. in ALARM) returns to IDLE/001 immediately and asynchronously, with the timer and partial code discarded.

Test Plan:
(TICK_CYCLES=10, EXIT_S=3, ENTRY_S=2, GREEN_S=2, CODE=16'h1234, MAX_TRIES=3)
- Reset then arm: release rst, pulse btn_arm -> input_color 001 -> 010; sec_left goes 3,2,1 at 10-cycle spacing; after 30 cycles input_color=011, sec_left=0.
- Trip and alarm: in ARMED assert sensor -> 101, sec_left=2; 20 cycles later -> 100, alarm_active=1. Then keys 1,2,3,4 -> 110, alarm_active=0; 20 cycles later -> 001.
- Disarm race: in ENTRY, complete 1,2,3,4 with the 4th key_valid on the expiry tick edge -> 110, never 100.
- Wrong codes: in ARMED enter 9999 twice -> tries_left 3->2->1, state stays 011. A third wrong code -> 100 immediately. Then enter 1234 -> 110, tries_left=3.
- Entry hygiene: keys 1,2, then key_clear, then 3,4,1,2,3,4 -> only the second 4-digit group (4123) counts as wrong; then 1,2,3,4 disarms. Digit 12 is ignored; keys pressed in IDLE have no effect.
- Async reset in ALARM: assert rst mid-cycle -> input_color=001, alarm_active=0, sec_left=0 before the next clk edge.
